// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin grant among NUM_REQ writeback
// requesters, with one registered write port (WE3/A3/WD3) and a saturating
// count of requesters that lost arbitration.
// Optional feature macro RF_CLEAR_EN: after reset, sweep x1..x31 to zero
// before entering RUN.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [5*NUM_REQ-1:0]    req_addr,
  input  logic [XLEN*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    WE3,
  output logic [4:0]              A3,
  output logic [XLEN-1:0]         WD3,
  output logic                    init_done,
  output logic [15:0]             stall_cnt
);

  localparam int unsigned PtrW = (NUM_REQ > 2) ? 2 : 1;

`ifdef RF_CLEAR_EN
  typedef enum logic {StClear, StRun} state_e;
  localparam state_e StReset = StClear;
`else
  typedef enum logic {StRun} state_e;
  localparam state_e StReset = StRun;
`endif

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic              we_q;
  logic [4:0]        a3_q;
  logic [XLEN-1:0]   wd_q;
  logic [15:0]       stall_q, stall_d;

  logic              run;
  logic              gnt_found;
  logic [PtrW-1:0]   gnt_idx;
  logic [PtrW:0]     scan;
  logic [PtrW-1:0]   idx;
  logic [4:0]        sel_addr;
  logic [XLEN-1:0]   sel_data;
  logic [2:0]        lost;
  logic [16:0]       stall_sum;

`ifdef RF_CLEAR_EN
  logic [4:0]        clr_q;

  // Clear-sweep address counter, starts at x1 after every reset
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_q <= 5'd1;
    end else if (state_q == StClear) begin
      clr_q <= clr_q + 5'd1;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: CLEAR leaves for RUN once x31 has been issued
  always_comb begin
    state_d = state_q;
`ifdef RF_CLEAR_EN
    if (state_q == StClear && clr_q == 5'd31) begin
      state_d = StRun;
    end
`endif
  end

  // FSM outputs: round-robin grant scanning from ptr_q upward with wrap
  always_comb begin
    run       = (state_q == StRun) && !rst;
    init_done = run;
    req_ready = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    idx       = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      scan = {1'b0, ptr_q} + (PtrW + 1)'(k);
      if (scan >= (PtrW + 1)'(NUM_REQ)) begin
        scan = scan - (PtrW + 1)'(NUM_REQ);
      end
      idx = scan[PtrW-1:0];
      if (run && !gnt_found && req_valid[idx]) begin
        gnt_found      = 1'b1;
        gnt_idx        = idx;
        req_ready[idx] = 1'b1;
      end
    end
  end

  // Granted address/data mux, next pointer and loser count
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    lost     = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[5*i +: 5];
        sel_data = req_data[XLEN*i +: XLEN];
      end
      if (run && req_valid[i] && !req_ready[i]) begin
        lost = lost + 3'd1;
      end
    end
    if (int'(gnt_idx) == int'(NUM_REQ) - 1) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx + PtrW'(1);
    end
    // Each losing requester counts one stall; clamp instead of wrapping
    stall_sum = {1'b0, stall_q} + {14'd0, lost};
    stall_d   = stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
  end

  // Write port, priority pointer and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      a3_q    <= '0;
      wd_q    <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
    end else begin
      we_q    <= 1'b0;
      stall_q <= stall_d;
`ifdef RF_CLEAR_EN
      if (state_q == StClear) begin
        we_q <= 1'b1;
        a3_q <= clr_q;
        wd_q <= '0;
      end
`endif
      if (gnt_found) begin
        // x0 writes are accepted but never reach the register file
        we_q  <= (sel_addr != 5'd0);
        a3_q  <= sel_addr;
        wd_q  <= sel_data;
        ptr_q <= ptr_d;
      end
    end
  end

  assign WE3       = we_q;
  assign A3        = a3_q;
  assign WD3       = wd_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (NUM_REQ=3, XLEN=32).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        init_done;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .NUM_REQ(3),
    .XLEN   (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .WE3      (WE3),
    .A3       (A3),
    .WD3      (WD3),
    .init_done(init_done),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  ready;   // expected same cycle
    logic        we;      // expected next cycle
    logic        chk_ad;
    logic [4:0]  a3;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef RF_CLEAR_EN
  task automatic sweep_check(input logic [2:0] v);
    req_valid = v;
    for (int k = 1; k <= 31; k++) begin
      tick();
      check("clr_we", WE3, 1);
      check("clr_a3", A3, k);
      check("clr_wd", WD3, 0);
      if (k < 31) begin
        check("clr_ready", req_ready, 0);
        check("clr_init", init_done, 0);
      end else begin
        check("clr_done", init_done, 1);
      end
    end
  endtask
`endif

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    tick();
    tick();
    check("rst_we", WE3, 0);
    check("rst_a3", A3, 0);
    check("rst_wd", WD3, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_init", init_done, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b0;
`ifdef RF_CLEAR_EN
    sweep_check(3'b000);
    tick();
`else
    #1;
`endif
    check("init_done", init_done, 1);
  endtask

  // Reference model state for the random phase
  logic        pv[3];
  logic [4:0]  pa[3];
  logic [31:0] pd[3];
  int          mptr, mstall, g, nvalid;
  logic        mwe;
  logic [4:0]  ma3;
  logic [31:0] mwd;

  initial begin
    vecs[0] = '{3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
                3'b010, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[1] = '{3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234},
                3'b001, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[2] = '{3'b111, {5'd9, 5'd7, 5'd3}, {32'h22, 32'h11, 32'h33},
                3'b010, 1'b1, 1'b1, 5'd7, 32'h11};
    vecs[3] = '{3'b111, {5'd9, 5'd7, 5'd3}, {32'h22, 32'h11, 32'h33},
                3'b100, 1'b1, 1'b1, 5'd9, 32'h22};
    vecs[4] = '{3'b111, {5'd9, 5'd7, 5'd3}, {32'h22, 32'h11, 32'h33},
                3'b001, 1'b1, 1'b1, 5'd3, 32'h33};
    vecs[5] = '{3'b000, {5'd9, 5'd7, 5'd3}, {32'h22, 32'h11, 32'h33},
                3'b000, 1'b0, 1'b1, 5'd3, 32'h33};
    vecs[6] = '{3'b100, {5'd31, 5'd0, 5'd0}, {32'hFFFFFFFF, 32'h0, 32'h0},
                3'b100, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF};

    do_reset();

    // Directed table from p=0
    foreach (vecs[i]) begin
      req_valid = vecs[i].valid;
      req_addr  = vecs[i].addr;
      req_data  = vecs[i].data;
      #1;
      check($sformatf("tbl%0d_ready", i), req_ready, vecs[i].ready);
      tick();
      check($sformatf("tbl%0d_we", i), WE3, vecs[i].we);
      if (vecs[i].chk_ad) begin
        check($sformatf("tbl%0d_a3", i), A3, vecs[i].a3);
        check($sformatf("tbl%0d_wd", i), WD3, vecs[i].wd);
      end
    end

    // All three valid for six cycles: order 0,1,2,0,1,2 and two losers per cycle
    do_reset();
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hC, 32'hB, 32'hA};
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("rr%0d_ready", c), req_ready, 3'b001 << (c % 3));
      tick();
    end
    check("rr_stall", stall_cnt, 12);

    // Single requester: granted every cycle
    req_valid = 3'b100;
    for (int c = 0; c < 4; c++) begin
      req_addr = {5'(c + 10), 5'd0, 5'd0};
      #1;
      check("solo_ready", req_ready, 3'b100);
      tick();
      check("solo_we", WE3, 1);
      check("solo_a3", A3, c + 10);
    end
    check("solo_stall", stall_cnt, 12);

    // Reset with requests pending: nothing granted, write dropped
    rst       = 1'b1;
    req_valid = 3'b111;
    #1;
    check("rstv_ready", req_ready, 0);
    check("rstv_init", init_done, 0);
    tick();
    check("rstv_we", WE3, 0);
    check("rstv_a3", A3, 0);
    check("rstv_wd", WD3, 0);
    check("rstv_stall", stall_cnt, 0);

`ifdef RF_CLEAR_EN
    // Reset mid-sweep restarts at x1 with no grants until RUN
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("mid_a3", A3, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_check(3'b111);
    req_valid = '0;
    tick();
`endif

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    mptr = 0; mstall = 0; mwe = 1'b0; ma3 = '0; mwd = '0;
    for (int c = 0; c < 400; c++) begin
      check("rnd_we", WE3, mwe);
      if (mwe) begin
        check("rnd_a3", A3, ma3);
        check("rnd_wd", WD3, mwd);
      end
      check("rnd_stall", stall_cnt, mstall);
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1'b1;
          pa[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pd[i] = $urandom;
        end
      end
      req_valid = {pv[2], pv[1], pv[0]};
      req_addr  = {pa[2], pa[1], pa[0]};
      req_data  = {pd[2], pd[1], pd[0]};
      #1;
      g = -1;
      nvalid = 0;
      for (int k = 0; k < 3; k++) begin
        if (pv[(mptr + k) % 3] && g < 0) g = (mptr + k) % 3;
        if (pv[k]) nvalid++;
      end
      check("rnd_ready", req_ready, (g < 0) ? 0 : (1 << g));
      if (g >= 0) begin
        mwe   = (pa[g] != 0);
        ma3   = pa[g];
        mwd   = pd[g];
        mptr  = (g + 1) % 3;
        pv[g] = 1'b0;
        nvalid--;
      end else begin
        mwe = 1'b0;
      end
      mstall = (mstall + nvalid > 65535) ? 65535 : mstall + nvalid;
      tick();
    end

    // Saturation: one loser per cycle for 70000 cycles
    do_reset();
    req_valid = 3'b011;
    repeat (70000) @(posedge clk);
    #1;
    check("sat_stall", stall_cnt, 16'hFFFF);
    repeat (5) tick();
    check("sat_hold", stall_cnt, 16'hFFFF);
    req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
